// File: rtl/wallace_acc_seq_pkg.sv
// Shared definitions for the wallace_acc_seq stream reducer.
//   state_t  : sequencer states (IDLE, ACCUM, DONE)
//   DATA_W   : operand / sum width, fixed by the wallaceTree reducer
//   NUM_OPS  : operands per accepted beat (tree has NUM_OPS + 1 inputs)
//   CNT_W    : default width of the saturating beat counter
package wallace_acc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DATA_W  = 16;
  localparam int NUM_OPS = 4;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/wallace_acc_seq_tree.sv
// wallaceTree: combinational 5-input modulo-2^16 adder.
// Three levels of 3:2 carry-save compression followed by one carry-propagate
// add. Carries shifted out of bit 15 are discarded at every level.
// Ports:
//   clock, reset          : present for interface compatibility, unused
//   io_data_i_0..4 [15:0] : addends
//   io_data_o      [15:0] : sum of all five addends, modulo 2^16
module wallaceTree
  import wallace_acc_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_data_i_0,
  input  logic [DATA_W-1:0] io_data_i_1,
  input  logic [DATA_W-1:0] io_data_i_2,
  input  logic [DATA_W-1:0] io_data_i_3,
  input  logic [DATA_W-1:0] io_data_i_4,
  output logic [DATA_W-1:0] io_data_o
);

  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;

  logic [DATA_W-1:0] s1, c1, s2, c2, s3, c3;
  logic [DATA_W-1:0] c1_sh, c2_sh, c3_sh;

  always_comb begin
    s1    = io_data_i_0 ^ io_data_i_1 ^ io_data_i_2;
    c1    = (io_data_i_0 & io_data_i_1) | (io_data_i_0 & io_data_i_2) |
            (io_data_i_1 & io_data_i_2);
    c1_sh = c1 << 1;

    s2    = s1 ^ c1_sh ^ io_data_i_3;
    c2    = (s1 & c1_sh) | (s1 & io_data_i_3) | (c1_sh & io_data_i_3);
    c2_sh = c2 << 1;

    s3    = s2 ^ c2_sh ^ io_data_i_4;
    c3    = (s2 & c2_sh) | (s2 & io_data_i_4) | (c2_sh & io_data_i_4);
    c3_sh = c3 << 1;

    io_data_o = s3 + c3_sh;
  end

endmodule

// File: rtl/wallace_acc_seq.sv
// wallace_acc_seq: folds a stream of 4-operand beats into one modulo-2^16 sum
// using wallaceTree, whose fifth input is the running accumulator.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   io_in_valid/ready        : input beat handshake (ready low only in DONE)
//   io_in_data_0..3          : the beat's four operands
//   io_in_last               : beat closes the stream (ignored without fire)
//   io_out_valid/ready       : result handshake (valid == DONE)
//   io_out_sum               : reduced sum
//   io_out_count             : beats folded, saturating at 2^CNT_W-1
module wallace_acc_seq
  import wallace_acc_seq_pkg::*;
#(
  parameter int DATA_W  = wallace_acc_seq_pkg::DATA_W,
  parameter int NUM_OPS = wallace_acc_seq_pkg::NUM_OPS,
  parameter int CNT_W   = wallace_acc_seq_pkg::CNT_W
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data_0,
  input  logic [DATA_W-1:0] io_in_data_1,
  input  logic [DATA_W-1:0] io_in_data_2,
  input  logic [DATA_W-1:0] io_in_data_3,
  input  logic              io_in_last,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_sum,
  output logic [CNT_W-1:0]  io_out_count
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_fb;
  logic [DATA_W-1:0] tree_sum;
  logic              fire;

  logic [NUM_OPS-1:0][DATA_W-1:0] ops;
  assign ops = {io_in_data_3, io_in_data_2, io_in_data_1, io_in_data_0};

  wallaceTree u_tree (
    .clock       (clock),
    .reset       (reset),
    .io_data_i_0 (ops[0]),
    .io_data_i_1 (ops[1]),
    .io_data_i_2 (ops[2]),
    .io_data_i_3 (ops[3]),
    .io_data_i_4 (acc_fb),
    .io_data_o   (tree_sum)
  );

  always_comb begin
    state_nxt    = state;
    io_in_ready  = (state != ST_DONE);
    io_out_valid = (state == ST_DONE);
    fire         = io_in_valid && io_in_ready;
    // First beat of a stream starts from zero regardless of acc contents.
    acc_fb       = (state == ST_IDLE) ? '0 : acc;
    unique case (state)
      ST_IDLE: begin
        if (fire) state_nxt = io_in_last ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (fire && io_in_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (io_out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        acc <= tree_sum;
        if (state == ST_IDLE)
          cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (cnt != '1)
          cnt <= cnt + 1'b1;
      end else if (state == ST_DONE && io_out_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

  assign io_out_sum   = acc;
  assign io_out_count = cnt;

endmodule

// File: tb/tb_wallace_acc_seq.sv
// Self-checking bench for wallace_acc_seq: directed scenarios plus randomized
// streams checked against a plain-arithmetic sum/count model.
module tb_wallace_acc_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_in_data_0, io_in_data_1, io_in_data_2, io_in_data_3;
  logic        io_in_last;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out_sum;
  logic [7:0]  io_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wallace_acc_seq #(.DATA_W(16), .NUM_OPS(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data_0 (io_in_data_0),
    .io_in_data_1 (io_in_data_1),
    .io_in_data_2 (io_in_data_2),
    .io_in_data_3 (io_in_data_3),
    .io_in_last   (io_in_last),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_sum   (io_out_sum),
    .io_out_count (io_out_count)
  );

  // All tasks start and end at posedge+1.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] a, b, c, d, input logic last);
    int n;
    n = 0;
    io_in_valid  = 1'b1;
    io_in_data_0 = a;
    io_in_data_1 = b;
    io_in_data_2 = c;
    io_in_data_3 = d;
    io_in_last   = last;
    while (!io_in_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL beat_accept_timeout: io_in_ready stayed %b, required 1", io_in_ready);
    end
    step();
    io_in_valid = 1'b0;
    io_in_last  = 1'b0;
  endtask

  task automatic handshake();
    io_out_ready = 1'b1;
    step();
    io_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_in_valid = 1'b0; io_in_last = 1'b0; io_out_ready = 1'b0;
    io_in_data_0 = '0; io_in_data_1 = '0; io_in_data_2 = '0; io_in_data_3 = '0;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({io_in_ready, io_out_valid, io_out_sum, io_out_count} !== {1'b1, 1'b0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b sum=%h count=%0d, required 1 0 0000 0",
               io_in_ready, io_out_valid, io_out_sum, io_out_count);
    end
  endtask

  task automatic test_single_beat();
    io_out_ready = 1'b1;
    send_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    checks++;
    if ({io_out_valid, io_out_sum, io_out_count} !== {1'b1, 16'h000A, 8'd1}) begin
      errors++;
      $display("FAIL single_result: valid=%b sum=%h count=%0d, required 1 000a 1",
               io_out_valid, io_out_sum, io_out_count);
    end
    step();
    io_out_ready = 1'b0;
    checks++;
    if ({io_out_valid, io_in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_return_idle: valid=%b ready=%b, required 0 1", io_out_valid, io_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_beat(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    send_beat(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early_valid: valid=%b, required 0", io_out_valid);
    end
    send_beat(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    checks++;
    if ({io_out_valid, io_out_sum, io_out_count} !== {1'b1, 16'hC000, 8'd3}) begin
      errors++;
      $display("FAIL b2b_result: valid=%b sum=%h count=%0d, required 1 c000 3",
               io_out_valid, io_out_sum, io_out_count);
    end
    handshake();
  endtask

  task automatic test_wrap();
    send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    checks++;
    if ({io_out_valid, io_out_sum, io_out_count} !== {1'b1, 16'hFFFC, 8'd1}) begin
      errors++;
      $display("FAIL wrap_one: valid=%b sum=%h count=%0d, required 1 fffc 1",
               io_out_valid, io_out_sum, io_out_count);
    end
    handshake();
    send_beat(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0);
    send_beat(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1);
    checks++;
    if ({io_out_valid, io_out_sum, io_out_count} !== {1'b1, 16'h0000, 8'd2}) begin
      errors++;
      $display("FAIL wrap_two: valid=%b sum=%h count=%0d, required 1 0000 2",
               io_out_valid, io_out_sum, io_out_count);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    send_beat(16'd7, 16'd8, 16'd9, 16'd10, 1'b1);
    io_in_valid = 1'b1;
    io_in_data_0 = 16'h1111; io_in_data_1 = 16'h2222;
    io_in_data_2 = 16'h3333; io_in_data_3 = 16'h4444;
    io_in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({io_in_ready, io_out_valid, io_out_sum, io_out_count} !== {1'b0, 1'b1, 16'h0022, 8'd1}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: ready=%b valid=%b sum=%h count=%0d, required 0 1 0022 1",
                 i, io_in_ready, io_out_valid, io_out_sum, io_out_count);
      end
      step();
    end
    io_in_valid = 1'b0;
    io_in_last  = 1'b0;
    handshake();
    checks++;
    if ({io_in_ready, io_out_valid, io_out_sum, io_out_count} !== {1'b1, 1'b0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL backpressure_release: ready=%b valid=%b sum=%h count=%0d, required 1 0 0000 0",
               io_in_ready, io_out_valid, io_out_sum, io_out_count);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    // A beat offered during reset must not be absorbed.
    reset = 1'b1;
    io_in_valid = 1'b1;
    io_in_data_0 = 16'd9; io_in_data_1 = 16'd9; io_in_data_2 = 16'd9; io_in_data_3 = 16'd9;
    io_in_last = 1'b1;
    step();
    reset = 1'b0;
    io_in_valid = 1'b0;
    io_in_last = 1'b0;
    checks++;
    if ({io_in_ready, io_out_valid, io_out_sum, io_out_count} !== {1'b1, 1'b0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b valid=%b sum=%h count=%0d, required 1 0 0000 0",
               io_in_ready, io_out_valid, io_out_sum, io_out_count);
    end
    send_beat(16'd5, 16'd0, 16'd0, 16'd0, 1'b1);
    checks++;
    if ({io_out_valid, io_out_sum, io_out_count} !== {1'b1, 16'h0005, 8'd1}) begin
      errors++;
      $display("FAIL reset_mid_result: valid=%b sum=%h count=%0d, required 1 0005 1",
               io_out_valid, io_out_sum, io_out_count);
    end
    // Reset while a result is pending drops it.
    reset = 1'b1;
    io_out_ready = 1'b1;
    step();
    reset = 1'b0;
    io_out_ready = 1'b0;
    checks++;
    if ({io_in_ready, io_out_valid, io_out_sum, io_out_count} !== {1'b1, 1'b0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_in_done: ready=%b valid=%b sum=%h count=%0d, required 1 0 0000 0",
               io_in_ready, io_out_valid, io_out_sum, io_out_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        io_in_valid = 1'b0;
        io_in_last  = 1'($urandom_range(0, 1));
        step();
      end
      send_beat(16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    end
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_early_valid: valid=%b, required 0", io_out_valid);
    end
    send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
    checks++;
    if ({io_out_valid, io_out_sum, io_out_count} !== {1'b1, 16'h0004, 8'd255}) begin
      errors++;
      $display("FAIL sat_result: valid=%b sum=%h count=%0d, required 1 0004 255",
               io_out_valid, io_out_sum, io_out_count);
    end
    handshake();
  endtask

  task automatic test_random_streams();
    for (int s = 0; s < 10; s++) begin
      int          len;
      longint      total;
      int          beats;
      logic [15:0] a, b, c, d;
      logic [15:0] exp_sum;
      logic [7:0]  exp_cnt;
      len   = $urandom_range(1, 12);
      total = 0;
      beats = 0;
      for (int k = 0; k < len; k++) begin
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
        total = total + a + b + c + d;
        beats++;
        if ($urandom_range(0, 3) == 0) begin
          io_in_valid = 1'b0;
          io_in_last  = 1'b1;
          step();
        end
        send_beat(a, b, c, d, (k == len - 1));
      end
      exp_sum = 16'(total % 65536);
      exp_cnt = (beats > 255) ? 8'd255 : 8'(beats);
      for (int w = $urandom_range(0, 3); w > 0; w--) step();
      checks++;
      if ({io_out_valid, io_out_sum, io_out_count} !== {1'b1, exp_sum, exp_cnt}) begin
        errors++;
        $display("FAIL random_stream[%0d]: valid=%b sum=%h count=%0d, required 1 %h %0d",
                 s, io_out_valid, io_out_sum, io_out_count, exp_sum, exp_cnt);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random_streams();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
